// File: rtl/prach_reshape_n_if.sv
// Sample/pair bus of the PRACH reshaper: per-lane TDM input samples in, even/odd pairs out.
interface prach_reshape_n_if #(
  parameter int NUM_LANE = 3,
  parameter int DW       = 16
);
  logic [NUM_LANE-1:0][DW-1:0] din_dq;
  logic                        din_dv;
  logic [7:0]                  din_chn;
  logic                        sync_in;
  logic [NUM_LANE-1:0][DW-1:0] dout_dp1;
  logic [NUM_LANE-1:0][DW-1:0] dout_dp2;
  logic                        dout_dv;
  logic [7:0]                  dout_chn;
  logic                        sync_out;
  logic                        err_chn;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );
endinterface

// File: rtl/prach_reshape_n.sv
// Pairs consecutive samples of each TDM channel into (even, odd) per-lane outputs.
// Latency 1 clock from odd sample to dout_dv; no backpressure, outputs hold between pairs.
module prach_reshape_n #(
  parameter int NUM_LANE = 3,
  parameter int DW       = 16,
  parameter int NUM_CHN  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  prach_reshape_n_if.slave bus
);

  localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

  typedef logic [NUM_LANE-1:0][DW-1:0] lanes_t;

  logic [NUM_CHN-1:0] phase_q, phase_d;
  lanes_t             hold_q [NUM_CHN];
  lanes_t             dp1_q, dp1_d;
  lanes_t             dp2_q, dp2_d;
  logic [7:0]         chn_q, chn_d;
  logic               dv_q, dv_d;
  logic               err_q, err_d;
  logic               sync_q;
  logic               hold_we;
  logic               in_range;
  logic [CW-1:0]      chn_idx;

  assign in_range = ({1'b0, bus.din_chn} < 9'(NUM_CHN));
  assign chn_idx  = bus.din_chn[CW-1:0];

  always_comb begin
    // sync wipes every phase first, so a same-cycle sample always starts a new pair
    phase_d = bus.sync_in ? '0 : phase_q;
    dp1_d   = dp1_q;
    dp2_d   = dp2_q;
    chn_d   = chn_q;
    dv_d    = 1'b0;
    err_d   = bus.din_dv && !in_range;
    hold_we = 1'b0;
    if (bus.din_dv && in_range) begin
      if (phase_d[chn_idx]) begin
        phase_d[chn_idx] = 1'b0;
        dp1_d            = hold_q[chn_idx];
        dp2_d            = bus.din_dq;
        chn_d            = bus.din_chn;
        dv_d             = 1'b1;
      end else begin
        phase_d[chn_idx] = 1'b1;
        hold_we          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      dp1_q   <= '0;
      dp2_q   <= '0;
      chn_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dp1_q   <= dp1_d;
      dp2_q   <= dp2_d;
      chn_q   <= chn_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      sync_q  <= bus.sync_in;
    end
  end

  // Holding words are qualified by the phase bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (hold_we) begin
      hold_q[chn_idx] <= bus.din_dq;
    end
  end

  assign bus.dout_dp1 = dp1_q;
  assign bus.dout_dp2 = dp2_q;
  assign bus.dout_chn = chn_q;
  assign bus.dout_dv  = dv_q;
  assign bus.err_chn  = err_q;
  assign bus.sync_out = sync_q;

endmodule

// File: tb/tb_prach_reshape_n.sv
// Scoreboard bench for prach_reshape_n: directed scenarios plus a randomized channel sweep.
module tb_prach_reshape_n;

  localparam int NUM_LANE = 3;
  localparam int DW       = 16;
  localparam int NUM_CHN  = 12;

  typedef logic [NUM_LANE-1:0][DW-1:0] lanes_t;

  typedef struct {
    lanes_t     p1;
    lanes_t     p2;
    logic [7:0] chn;
    int         due;
  } pair_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  prach_reshape_n_if #(.NUM_LANE(NUM_LANE), .DW(DW)) bus ();

  prach_reshape_n #(
    .NUM_LANE (NUM_LANE),
    .DW       (DW),
    .NUM_CHN  (NUM_CHN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an unpaired sample per channel waits in 'pending' until its partner arrives.
  lanes_t pending [int];
  pair_t  pq [$];
  int     eq [$];
  int     sq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input bit dv, input int chn, input lanes_t d, input bit sync);
    pair_t p;
    @(posedge clk);
    #1;
    bus.din_dv  = dv;
    bus.din_chn = 8'(chn);
    bus.din_dq  = d;
    bus.sync_in = sync;
    if (sync) begin
      pending.delete();
      sq.push_back(cyc + 1);
    end
    if (dv) begin
      if (chn >= NUM_CHN) begin
        eq.push_back(cyc + 1);
      end else if (pending.exists(chn)) begin
        p.p1  = pending[chn];
        p.p2  = d;
        p.chn = 8'(chn);
        p.due = cyc + 1;
        pq.push_back(p);
        pending.delete(chn);
      end else begin
        pending[chn] = d;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, '0, 1'b0);
  endtask

  function automatic lanes_t rnd_lanes();
    lanes_t d;
    for (int l = 0; l < NUM_LANE; l++) begin
      case ($urandom_range(0, 2))
        0:       d[l] = DW'(32'h8000);
        1:       d[l] = DW'(32'h7FFF);
        default: d[l] = DW'($urandom);
      endcase
    end
    return d;
  endfunction

  // Monitor: compares every cycle against the head of the expectation queues.
  lanes_t     last_p1, last_p2;
  logic [7:0] last_chn;
  bit         exp_dv, exp_err, exp_sync;
  pair_t      cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_p1  = '0;
      last_p2  = '0;
      last_chn = '0;
    end else begin
      exp_dv = (pq.size() > 0) && (pq[0].due == cyc);
      chk("dout_dv", 64'(bus.dout_dv), 64'(exp_dv));
      if (exp_dv) begin
        cur      = pq.pop_front();
        last_p1  = cur.p1;
        last_p2  = cur.p2;
        last_chn = cur.chn;
      end
      chk("dout_dp1", 64'(bus.dout_dp1), 64'(last_p1));
      chk("dout_dp2", 64'(bus.dout_dp2), 64'(last_p2));
      chk("dout_chn", 64'(bus.dout_chn), 64'(last_chn));
      exp_err = (eq.size() > 0) && (eq[0] == cyc);
      if (exp_err) void'(eq.pop_front());
      chk("err_chn", 64'(bus.err_chn), 64'(exp_err));
      exp_sync = (sq.size() > 0) && (sq[0] == cyc);
      if (exp_sync) void'(sq.pop_front());
      chk("sync_out", 64'(bus.sync_out), 64'(exp_sync));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_dp1"},  64'(bus.dout_dp1), 64'd0);
    chk({tag, "_dp2"},  64'(bus.dout_dp2), 64'd0);
    chk({tag, "_chn"},  64'(bus.dout_chn), 64'd0);
    chk({tag, "_dv"},   64'(bus.dout_dv),  64'd0);
    chk({tag, "_sync"}, 64'(bus.sync_out), 64'd0);
    chk({tag, "_err"},  64'(bus.err_chn),  64'd0);
  endtask

  initial begin
    lanes_t a, b, c, e;
    int     chn;
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    bus.din_dv  = 1'b0;
    bus.din_chn = '0;
    bus.din_dq  = '0;
    bus.sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // single channel, lanes {1,2,3} then {4,5,6}
    for (int l = 0; l < NUM_LANE; l++) begin
      a[l] = DW'(l + 1);
      b[l] = DW'(l + 4);
    end
    send(1'b1, 0, a, 1'b0);
    send(1'b1, 0, b, 1'b0);
    idle(3);

    // interleaved channels 0 and 5
    a = rnd_lanes(); b = rnd_lanes(); c = rnd_lanes(); e = rnd_lanes();
    send(1'b1, 0, a, 1'b0);
    send(1'b1, 5, b, 1'b0);
    send(1'b1, 0, c, 1'b0);
    send(1'b1, 5, e, 1'b0);
    idle(3);

    // sync arriving mid-pair drops the pending even sample
    a = rnd_lanes(); b = rnd_lanes(); c = rnd_lanes();
    send(1'b1, 2, a, 1'b0);
    send(1'b1, 2, b, 1'b1);
    send(1'b1, 2, c, 1'b0);
    idle(2);
    send(1'b0, 0, '0, 1'b1);
    idle(3);

    // out-of-range channel between an even/odd pair
    a = rnd_lanes(); b = rnd_lanes();
    send(1'b1, 3, a, 1'b0);
    send(1'b1, 12, rnd_lanes(), 1'b0);
    send(1'b1, 3, b, 1'b0);
    send(1'b1, 255, rnd_lanes(), 1'b0);
    idle(3);

    // reset mid-pair: outputs hold a nonzero pair and sync_out is due when reset hits
    for (int l = 0; l < NUM_LANE; l++) begin
      a[l] = DW'(16'h1111 * (l + 1));
      b[l] = DW'(16'h2222 * (l + 1));
    end
    send(1'b1, 4, a, 1'b0);
    send(1'b1, 4, b, 1'b0);
    c = rnd_lanes();
    send(1'b1, 1, c, 1'b1);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.din_dv  = 1'b0;
    bus.sync_in = 1'b0;
    pending.delete();
    pq.delete();
    eq.delete();
    sq.delete();
    #1;
    check_all_zero("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_rst");
    rst_n = 1'b1;
    a = rnd_lanes(); b = rnd_lanes();
    send(1'b1, 1, a, 1'b0);
    send(1'b1, 1, b, 1'b0);
    idle(3);

    // random sweep over every channel with gaps, occasional sync and bad channels
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      chn = ($urandom_range(0, 19) == 0) ? $urandom_range(NUM_CHN, 255)
                                         : $urandom_range(0, NUM_CHN - 1);
      send(1'b1, chn, rnd_lanes(), ($urandom_range(0, 49) == 0));
    end
    idle(5);
    chk("drain", 64'(pq.size() + eq.size() + sq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
